arrow_input_conditioner: RTL and testbench

Upstream stage of the snake game core. It conditions the four raw arrow buttons by synchronising, debouncing and edge-detecting them. It arbitrates simultaneous presses, rejects 180° reversals, and holds a pending heading that is committed only on the game step pulse. It also maintains a free-running LFSR seed perturbed by press timing, which the game core uses for apple placement.

---
 rtl/arrow_input_conditioner.sv | 76 +++++++
 tb/tb_arrow_input_conditioner.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/arrow_input_conditioner.sv
// arrow_input_conditioner: synchronise, debounce and edge-detect four arrow buttons, arbitrate, reject reversals, commit heading on step, keep a timing-perturbed LFSR seed
// Ports: clk; reset (sync, active-low); arrow_up/arrow_down (raw, active-low); arrow_left/arrow_right (raw, active-high);
//        step (commit pulse); game_reset (restart pulse); dir (committed heading); pending (next heading);
//        press_accept (pulse when a press updates pending); seed (nonzero random seed)
module arrow_input_conditioner #(
    parameter int              DEBOUNCE_CYCLES = 100000,
    parameter int              CNT_W           = 17,
    parameter logic [15:0]     SEED_INIT       = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arrow_up,
    input  logic        arrow_down,
    input  logic        arrow_left,
    input  logic        arrow_right,
    input  logic        step,
    input  logic        game_reset,
    output logic [1:0]  dir,
    output logic [1:0]  pending,
    output logic        press_accept,
    output logic [15:0] seed
);
    // bit index doubles as heading code: 0 up, 1 down, 2 left, 3 right
    localparam logic [3:0]       IDLE = 4'b0011;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic [3:0]       s1, s2, pressed, deb, deb_nxt, ev;
    logic [CNT_W-1:0] cnt [4];
    logic [15:0]      ts, lfsr_next, mix;
    logic [1:0]       r, ref_h;
    logic             any_ev, accept;
    assign pressed   = s2 ^ IDLE;
    assign any_ev    = |ev;
    assign r         = ev[0] ? 2'd0 : ev[1] ? 2'd1 : ev[2] ? 2'd2 : 2'd3;
    // a press racing a step is judged against the heading being committed
    assign ref_h     = step ? pending : dir;
    assign accept    = any_ev && !game_reset && (r != (ref_h ^ 2'd1));
    assign lfsr_next = seed[0] ? ({1'b0, seed[15:1]} ^ 16'hB400) : {1'b0, seed[15:1]};
    assign mix       = lfsr_next ^ ts;
    always_comb begin
        deb_nxt = deb;
        for (int i = 0; i < 4; i++)
            deb_nxt[i] = (pressed[i] != deb[i] && cnt[i] == LAST) ? pressed[i] : deb[i];
        ev = deb_nxt & ~deb;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1           <= IDLE;
            s2           <= IDLE;
            deb          <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
            ts           <= '0;
            seed         <= SEED_INIT;
            dir          <= 2'd0;
            pending      <= 2'd0;
            press_accept <= 1'b0;
        end else begin
            s1  <= {arrow_right, arrow_left, arrow_down, arrow_up};
            s2  <= s1;
            deb <= deb_nxt;
            for (int i = 0; i < 4; i++)
                cnt[i] <= (pressed[i] == deb[i] || cnt[i] == LAST) ? '0 : cnt[i] + 1'b1;
            ts   <= ts + 1'b1;
            // press timing is folded in; a zero result would lock the LFSR
            seed <= any_ev ? ((mix == 16'd0) ? SEED_INIT : mix) : lfsr_next;
            if (game_reset) begin
                dir          <= 2'd0;
                pending      <= 2'd0;
                press_accept <= 1'b0;
            end else begin
                if (step) dir <= pending;
                if (accept) pending <= r;
                press_accept <= accept;
            end
        end
    end
endmodule

// File: tb/tb_arrow_input_conditioner.sv
// tb_arrow_input_conditioner: directed stimulus with a cycle model and literal checks for arrow_input_conditioner
module tb_arrow_input_conditioner;
    localparam int D = 8;
    logic        clk = 0, reset = 0;
    logic        arrow_up = 1, arrow_down = 1, arrow_left = 0, arrow_right = 0;
    logic        step = 0, game_reset = 0;
    logic [1:0]  dir, pending;
    logic        press_accept;
    logic [15:0] seed;
    int          total = 0, bad = 0, pa_cnt = 0;
    bit          started = 0;
    // model state
    bit          h [4][D+2];
    bit   [3:0]  m_deb;
    logic [1:0]  m_dir, m_pend;
    logic        m_pa;
    logic [15:0] m_seed, m_ts;

    arrow_input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(17), .SEED_INIT(16'hACE1)) dut (
        .clk(clk), .reset(reset), .arrow_up(arrow_up), .arrow_down(arrow_down),
        .arrow_left(arrow_left), .arrow_right(arrow_right), .step(step), .game_reset(game_reset),
        .dir(dir), .pending(pending), .press_accept(press_accept), .seed(seed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // behavioural model: a button's debounced level flips once the last D synchronised
    // samples (raw delayed by two edges) all disagree with it
    always @(posedge clk) begin
        bit [3:0]    nraw, ev;
        bit          flip;
        int          r;
        logic [1:0]  refh;
        logic        acc;
        logic [15:0] nxt, mx;
        nraw = {arrow_right, arrow_left, ~arrow_down, ~arrow_up};
        if (!reset) begin
            for (int b = 0; b < 4; b++) for (int j = 0; j < D + 2; j++) h[b][j] = 0;
            m_deb = 0; m_ts = 0; m_seed = 16'hACE1; m_dir = 0; m_pend = 0; m_pa = 0;
            started = 1;
        end else if (started) begin
            ev = 0;
            for (int b = 0; b < 4; b++) begin
                for (int j = D + 1; j > 0; j--) h[b][j] = h[b][j-1];
                h[b][0] = nraw[b];
                flip = 1;
                for (int j = 2; j < D + 2; j++) if (h[b][j] == m_deb[b]) flip = 0;
                if (flip) begin
                    ev[b] = !m_deb[b];
                    m_deb[b] = !m_deb[b];
                end
            end
            r = 3;
            for (int b = 3; b >= 0; b--) if (ev[b]) r = b;
            refh = step ? m_pend : m_dir;
            acc = (ev != 0) && !game_reset && (r[1:0] != (refh ^ 2'd1));
            nxt = m_seed[0] ? ((m_seed >> 1) ^ 16'hB400) : (m_seed >> 1);
            mx = nxt ^ m_ts;
            m_seed = (ev != 0) ? ((mx == 0) ? 16'hACE1 : mx) : nxt;
            m_ts = m_ts + 1;
            if (game_reset) begin
                m_dir = 0; m_pend = 0; m_pa = 0;
            end else begin
                if (step) m_dir = m_pend;
                if (acc) m_pend = r[1:0];
                m_pa = acc;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (started) begin
            chk("dir", 16'(dir), 16'(m_dir));
            chk("pending", 16'(pending), 16'(m_pend));
            chk("press_accept", 16'(press_accept), 16'(m_pa));
            chk("seed", seed, m_seed);
            if (seed == 16'd0) chk("seed_nonzero", seed, 16'hACE1);
            if (press_accept) pa_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int b, input bit p);
        case (b)
            0: arrow_up = !p;
            1: arrow_down = !p;
            2: arrow_left = p;
            default: arrow_right = p;
        endcase
    endtask

    // press so the debounced event lands exactly on the cycle carrying st/gr
    task automatic fire(input int b, input bit st, input bit gr);
        set_btn(b, 1);
        tick(D + 1);
        step = st; game_reset = gr;
        tick(1);
        step = 0; game_reset = 0;
        tick(4);
    endtask

    task automatic rel(input int b);
        set_btn(b, 0);
        tick(D + 4);
    endtask

    task automatic pulse_step();
        step = 1; tick(1); step = 0; tick(1);
    endtask

    task automatic pulse_gr();
        game_reset = 1; tick(1); game_reset = 0; tick(1);
    endtask

    initial begin
        int base;
        // 1: reset
        tick(3);
        chk("rst_seed", seed, 16'hACE1);
        chk("rst_dir", 16'(dir), 16'd0);
        chk("rst_pending", 16'(pending), 16'd0);
        chk("rst_pa", 16'(press_accept), 16'd0);
        reset = 1;
        tick(1);
        chk("seed_first_shift", seed, 16'hE270);
        tick(3);
        // 2: bouncing right then a clean hold
        base = pa_cnt;
        for (int k = 0; k < 3; k++) begin
            set_btn(3, 1); tick(4); set_btn(3, 0); tick(4);
        end
        chk("bounce_no_pa", 16'(pa_cnt - base), 16'd0);
        set_btn(3, 1);
        tick(20);
        chk("right_one_pa", 16'(pa_cnt - base), 16'd1);
        chk("right_pending", 16'(pending), 16'd3);
        chk("right_dir_held", 16'(dir), 16'd0);
        pulse_step();
        chk("right_commit", 16'(dir), 16'd3);
        tick(20);
        chk("hold_no_more_pa", 16'(pa_cnt - base), 16'd1);
        rel(3);
        // 3: reversal down from up
        pulse_gr();
        chk("gr_dir", 16'(dir), 16'd0);
        base = pa_cnt;
        fire(1, 0, 0);
        chk("down_rejected_pa", 16'(pa_cnt - base), 16'd0);
        chk("down_rejected_pend", 16'(pending), 16'd0);
        pulse_step();
        chk("down_dir", 16'(dir), 16'd0);
        rel(1);
        // 4: right with step while pending=left
        fire(2, 0, 0);
        chk("left_pending", 16'(pending), 16'd2);
        chk("left_dir", 16'(dir), 16'd0);
        rel(2);
        base = pa_cnt;
        fire(3, 1, 0);
        chk("step_right_dir", 16'(dir), 16'd2);
        chk("step_right_pend", 16'(pending), 16'd2);
        chk("step_right_pa", 16'(pa_cnt - base), 16'd0);
        rel(3);
        // 5: simultaneous up and left
        base = pa_cnt;
        set_btn(0, 1); set_btn(2, 1);
        tick(D + 4);
        chk("simul_pending", 16'(pending), 16'd0);
        chk("simul_pa", 16'(pa_cnt - base), 16'd1);
        chk("simul_dir", 16'(dir), 16'd2);
        set_btn(0, 0); set_btn(2, 0);
        tick(D + 4);
        // 6: game_reset beats step and press
        pulse_step();
        chk("to_up_dir", 16'(dir), 16'd0);
        fire(3, 0, 0);
        pulse_step();
        chk("to_right_dir", 16'(dir), 16'd3);
        chk("to_right_pend", 16'(pending), 16'd3);
        rel(3);
        base = pa_cnt;
        fire(0, 1, 1);
        chk("gr_race_dir", 16'(dir), 16'd0);
        chk("gr_race_pend", 16'(pending), 16'd0);
        chk("gr_race_pa", 16'(pa_cnt - base), 16'd0);
        rel(0);
        fire(1, 0, 0);
        chk("after_gr_down_pend", 16'(pending), 16'd0);
        chk("after_gr_down_pa", 16'(pa_cnt - base), 16'd0);
        tick(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
